// File: rtl/coin_pkg.sv
// Shared types and constants for the coin input front end.
// Channel indices, FSM states and a small counting helper.
package coin_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EMIT = 2'd1,
      LOCK = 2'd2
   } coin_state_t;

   localparam int CH_B1  = 0;
   localparam int CH_B2  = 1;
   localparam int CH_B3  = 2;
   localparam int NUM_CH = 3;

   // Number of channels raising a press flag in the same cycle.
   function automatic logic [1:0] rise_count(
      input logic [NUM_CH-1:0] r
   );
      logic [1:0] n;
      n = 2'd0;
      for (int i = 0; i < NUM_CH; i++) begin
         n = n + {1'b0, r[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/coin_debounce_ch.sv
// One coin channel: 2-flop synchroniser, debounce filter and
// a registered one-cycle flag on each accepted press.
module coin_debounce_ch #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic rise
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          s1;
   logic          s2;
   logic          stable;
   logic          stable_q;
   logic [CW-1:0] cnt;

   // Synchronise, filter and flag the 0->1 transition of the stable level.
   always_ff @(posedge clk) begin
      if (!reset) begin
         s1       <= 1'b0;
         s2       <= 1'b0;
         stable   <= 1'b0;
         stable_q <= 1'b0;
         cnt      <= '0;
         rise     <= 1'b0;
      end else begin
         s1       <= raw;
         s2       <= s1;
         stable_q <= stable;
         rise     <= stable & ~stable_q;
         if (s2 == stable) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            stable <= s2;
            cnt    <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/coin_input_conditioner.sv
// Coin button front end: three debounced channels feeding an arbiter
// that emits at most one clean coin pulse, then locks out briefly.
module coin_input_conditioner
   import coin_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int LOCKOUT_CYCLES  = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic B1,
   input  logic B2,
   input  logic B3,
   output logic B1_p,
   output logic B2_p,
   output logic B3_p,
   output logic coin_err,
   output logic coin_drop
);

   localparam int LW   = (LOCKOUT_CYCLES > 0) ? $clog2(LOCKOUT_CYCLES + 1) : 1;
   localparam int LCMP = (LOCKOUT_CYCLES > 0) ? LOCKOUT_CYCLES - 1 : 0;
   localparam logic [LW-1:0] LOCK_LAST = LW'(LCMP);

   logic [NUM_CH-1:0] raw;
   logic [NUM_CH-1:0] rise;
   logic [NUM_CH-1:0] b_p;
   logic [1:0]        nrise;
   coin_state_t       state;
   logic [LW-1:0]     lock_cnt;

   assign raw[CH_B1] = B1;
   assign raw[CH_B2] = B2;
   assign raw[CH_B3] = B3;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      coin_debounce_ch #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_ch (
         .clk  (clk),
         .reset(reset),
         .raw  (raw[i]),
         .rise (rise[i])
      );
   end

   assign nrise = rise_count(rise);

   // Arbiter: accept a lone press in IDLE, flag collisions and late presses.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         lock_cnt  <= '0;
         b_p       <= '0;
         coin_err  <= 1'b0;
         coin_drop <= 1'b0;
      end else begin
         b_p       <= '0;
         coin_err  <= 1'b0;
         coin_drop <= 1'b0;
         unique case (state)
            IDLE: begin
               if (nrise == 2'd1) begin
                  b_p   <= rise;
                  state <= EMIT;
               end else if (nrise > 2'd1) begin
                  coin_err <= 1'b1;
               end
            end
            EMIT: begin
               lock_cnt  <= '0;
               coin_drop <= |rise;
               state     <= (LOCKOUT_CYCLES == 0) ? IDLE : LOCK;
            end
            LOCK: begin
               coin_drop <= |rise;
               if (lock_cnt == LOCK_LAST) begin
                  lock_cnt <= '0;
                  state    <= IDLE;
               end else begin
                  lock_cnt <= lock_cnt + LW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign B1_p = b_p[CH_B1];
   assign B2_p = b_p[CH_B2];
   assign B3_p = b_p[CH_B3];

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Directed bench for coin_input_conditioner (D=4, L=2).
// Expected outputs are hand-derived per cycle.
module tb_coin_input_conditioner;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic B1 = 1'b0;
   logic B2 = 1'b0;
   logic B3 = 1'b0;
   logic B1_p;
   logic B2_p;
   logic B3_p;
   logic coin_err;
   logic coin_drop;

   int comps = 0;
   int errs  = 0;

   // exp bit order: {B1_p, B2_p, B3_p, coin_err, coin_drop}
   typedef struct {
      logic       rst;
      logic [2:0] b;
      logic [4:0] exp;
      string      name;
   } vec_t;

   vec_t vq[$];

   localparam logic [4:0] P1   = 5'b10000;
   localparam logic [4:0] P2   = 5'b01000;
   localparam logic [4:0] P3   = 5'b00100;
   localparam logic [4:0] PERR = 5'b00010;
   localparam logic [4:0] PDRP = 5'b00001;
   localparam logic [4:0] NONE = 5'b00000;

   always #20 clk = ~clk;

   coin_input_conditioner #(
      .DEBOUNCE_CYCLES(4),
      .LOCKOUT_CYCLES (2)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .B1       (B1),
      .B2       (B2),
      .B3       (B3),
      .B1_p     (B1_p),
      .B2_p     (B2_p),
      .B3_p     (B3_p),
      .coin_err (coin_err),
      .coin_drop(coin_drop)
   );

   // b is {B3, B2, B1}; vector k is sampled at edge k, checked 1 ns later.
   task automatic step(input logic rst, input logic [2:0] b,
                       input logic [4:0] exp, input string name);
      logic [4:0] got;
      @(negedge clk);
      reset = rst;
      B1 = b[0];
      B2 = b[1];
      B3 = b[2];
      @(posedge clk);
      #1;
      got = {B1_p, B2_p, B3_p, coin_err, coin_drop};
      comps++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s t=%0t got=%b want=%b", name, $time, got, exp);
      end
   endtask

   task automatic add(input int n, input logic rst, input logic [2:0] b,
                      input int at, input logic [4:0] p, input string name);
      vec_t v;
      for (int i = 0; i < n; i++) begin
         v.rst  = rst;
         v.b    = b;
         v.exp  = (i == at) ? p : NONE;
         v.name = name;
         vq.push_back(v);
      end
   endtask

   initial begin
      // Reset held for two edges.
      add(2, 1'b0, 3'b000, -1, NONE, "reset");
      add(2, 1'b1, 3'b000, -1, NONE, "idle");
      // B1 held: one pulse after edge 7, none afterwards.
      add(16, 1'b1, 3'b001, 7, P1, "b1_held");
      add(10, 1'b1, 3'b000, -1, NONE, "b1_release");
      // Second B1 press after release pulses again.
      add(10, 1'b1, 3'b001, 7, P1, "b1_again");
      add(10, 1'b1, 3'b000, -1, NONE, "b1_release2");
      // B2 bounce 1,0,1,1,0 then held: pulse 7 edges after last rise.
      add(1, 1'b1, 3'b010, -1, NONE, "b2_glitch");
      add(1, 1'b1, 3'b000, -1, NONE, "b2_glitch");
      add(2, 1'b1, 3'b010, -1, NONE, "b2_glitch");
      add(1, 1'b1, 3'b000, -1, NONE, "b2_glitch");
      add(12, 1'b1, 3'b010, 7, P2, "b2_settle");
      add(10, 1'b1, 3'b000, -1, NONE, "b2_release");
      // B1 and B3 together: collision flagged, no coin.
      add(12, 1'b1, 3'b101, 7, PERR, "b1b3_same");
      add(10, 1'b1, 3'b000, -1, NONE, "b1b3_release");

      foreach (vq[k]) begin
         step(vq[k].rst, vq[k].b, vq[k].exp, vq[k].name);
      end

      // B2 at edge 0, B3 one edge later: B2 pulse, then B3 dropped.
      step(1'b1, 3'b010, NONE, "b2b3_e0");
      for (int k = 1; k < 14; k++) begin
         if (k == 7)
            step(1'b1, 3'b110, P2, "b2b3_pulse");
         else if (k == 8)
            step(1'b1, 3'b110, PDRP, "b2b3_drop");
         else
            step(1'b1, 3'b110, NONE, "b2b3_quiet");
      end
      for (int k = 0; k < 10; k++) begin
         step(1'b1, 3'b000, NONE, "b2b3_release");
      end

      // B3 pressed, reset at edge 3 with B3 still held, then released.
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 3'b100, NONE, "b3_pre_reset");
      end
      step(1'b0, 3'b100, NONE, "b3_in_reset");
      step(1'b0, 3'b100, NONE, "b3_in_reset");
      for (int k = 0; k < 12; k++) begin
         if (k == 7)
            step(1'b1, 3'b100, P3, "b3_post_reset");
         else
            step(1'b1, 3'b100, NONE, "b3_post_quiet");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, errs);
      $finish;
   end

endmodule
